// File: rtl/ring_pkg.sv
// Shared definitions for the ring transmit arbiter: slot types, header layout,
// FSM state encoding and the header-word builder.
package ring_pkg;

    localparam logic [3:0] SLOT_TOKEN     = 4'd1;
    localparam logic [3:0] SLOT_NULL      = 4'd7;
    localparam logic [3:0] SLOT_MESSAGE   = 4'd8;
    localparam logic [3:0] SLOT_BROADCAST = 4'd12;
    localparam logic [3:0] NULL_SLOT      = SLOT_NULL;

    localparam int HDR_SRC_LSB  = 10;
    localparam int HDR_TYPE_LSB = 6;
    localparam int HDR_LEN_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_TOKEN = 3'd1,
        ST_WAIT_N     = 3'd2,
        ST_SEND_HDR   = 3'd3,
        ST_SEND_PAY   = 3'd4
    } tx_state_e;

    function automatic logic [31:0] make_header(input logic [3:0] src,
                                                input logic [3:0] msg_type,
                                                input logic [5:0] len);
        logic [31:0] hdr;
        hdr = 32'd0;
        hdr[HDR_SRC_LSB  +: 4] = src;
        hdr[HDR_TYPE_LSB +: 4] = msg_type;
        hdr[HDR_LEN_LSB  +: 6] = len;
        return hdr;
    endfunction

endpackage

// File: rtl/ring_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above rrPtr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rrPtr,
    output logic [NREQ-1:0] gntOneHot,
    output logic [IW-1:0]   gntIdx,
    output logic            valid
);

    int            cand_s;
    logic [IW-1:0] cand_idx_s;
    logic          found_s;

    // Scan requesters starting at the pointer and keep the first hit
    always_comb begin
        cand_s     = 0;
        cand_idx_s = '0;
        found_s    = 1'b0;
        gntIdx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s     = int'(rrPtr) + k;
            cand_s     = (cand_s >= NREQ) ? (cand_s - NREQ) : cand_s;
            cand_idx_s = cand_s[IW-1:0];
            if (!found_s && req[cand_idx_s]) begin
                found_s = 1'b1;
                gntIdx  = cand_idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Expand the chosen index to one-hot
    always_comb begin
        gntOneHot = {NREQ{1'b0}};
        if (found_s) begin
            gntOneHot[gntIdx] = 1'b1;
        end else begin
            gntOneHot = {NREQ{1'b0}};
        end
        valid = found_s;
    end

endmodule

// File: rtl/ring_tx_arbiter.sv
// Round-robin sharing of the ring transmit path: capture the Token, skip the
// outstanding train, then emit the header and payload words of one sender.
module ring_tx_arbiter
    import ring_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         whichCore,
    input  logic [3:0]         copyCore,
    input  logic [NREQ-1:0]    req,
    input  logic [4*NREQ-1:0]  reqDest,
    input  logic [4*NREQ-1:0]  reqType,
    input  logic [6*NREQ-1:0]  reqLen,
    input  logic [32*NREQ-1:0] reqData,
    output logic [NREQ-1:0]    dataRd,
    output logic [NREQ-1:0]    sent,
    input  logic [31:0]        RingIn,
    input  logic [3:0]         SlotTypeIn,
    input  logic [3:0]         SrcDestIn,
    output logic [31:0]        txRingOut,
    output logic [3:0]         txSlotTypeOut,
    output logic [3:0]         txSrcDestOut,
    output logic               txDriveRing,
    output logic               txWaiting
);

    localparam int            IW       = $clog2(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(32'd1);

    tx_state_e       state_r, state_n;
    logic [IW-1:0]   rr_ptr_r, rr_ptr_n, gnt_r, gnt_n, next_ptr_s;
    logic [NREQ-1:0] gnt_oh_r, gnt_oh_n, pick_oh_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_valid_s;
    logic [3:0]      dest_r, dest_n, type_r, type_n, core_inc_s, msg_slot_s;
    logic [5:0]      len_r, len_n, cnt_r, cnt_n;
    logic [7:0]      burst_r, burst_n;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req       (req),
        .rrPtr     (rr_ptr_r),
        .gntOneHot (pick_oh_s),
        .gntIdx    (pick_idx_s),
        .valid     (pick_valid_s)
    );

    // Broadcast uses a 4-bit wrap of whichCore+1, so core 15 compares as 0
    assign core_inc_s = whichCore + 4'd1;
    assign msg_slot_s = ((dest_r == whichCore) && (core_inc_s < copyCore)) ? SLOT_BROADCAST : SLOT_MESSAGE;
    assign next_ptr_s = (gnt_r == LAST_IDX) ? {IW{1'b0}} : (gnt_r + ONE_IDX);

    // State and descriptor registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= {IW{1'b0}};
            gnt_r    <= {IW{1'b0}};
            gnt_oh_r <= {NREQ{1'b0}};
            dest_r   <= 4'd0;
            type_r   <= 4'd0;
            len_r    <= 6'd0;
            cnt_r    <= 6'd0;
            burst_r  <= 8'd0;
        end else begin
            state_r  <= state_n;
            rr_ptr_r <= rr_ptr_n;
            gnt_r    <= gnt_n;
            gnt_oh_r <= gnt_oh_n;
            dest_r   <= dest_n;
            type_r   <= type_n;
            len_r    <= len_n;
            cnt_r    <= cnt_n;
            burst_r  <= burst_n;
        end
    end

    // Next-state and ring/requester outputs; idle states pass the ring through
    always_comb begin
        state_n       = state_r;
        rr_ptr_n      = rr_ptr_r;
        gnt_n         = gnt_r;
        gnt_oh_n      = gnt_oh_r;
        dest_n        = dest_r;
        type_n        = type_r;
        len_n         = len_r;
        cnt_n         = cnt_r;
        burst_n       = burst_r;
        txDriveRing   = 1'b0;
        txWaiting     = 1'b0;
        txRingOut     = RingIn;
        txSlotTypeOut = SlotTypeIn;
        txSrcDestOut  = SrcDestIn;
        dataRd        = {NREQ{1'b0}};
        sent          = {NREQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gnt_n    = pick_idx_s;
                    gnt_oh_n = pick_oh_s;
                    dest_n   = reqDest[pick_idx_s*4 +: 4];
                    type_n   = reqType[pick_idx_s*4 +: 4];
                    len_n    = reqLen[pick_idx_s*6 +: 6];
                    state_n  = ST_WAIT_TOKEN;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_WAIT_TOKEN: begin
                txWaiting = 1'b1;
                if (SlotTypeIn == SLOT_TOKEN) begin
                    txDriveRing = 1'b1;
                    txRingOut   = RingIn + {26'd0, len_r} + 32'd1;
                    if (RingIn[7:0] == 8'd0) begin
                        state_n = ST_SEND_HDR;
                    end else begin
                        burst_n = RingIn[7:0];
                        state_n = ST_WAIT_N;
                    end
                end else begin
                    state_n = ST_WAIT_TOKEN;
                end
            end
            ST_WAIT_N: begin
                burst_n = burst_r - 8'd1;
                if (burst_r == 8'd1) begin
                    state_n = ST_SEND_HDR;
                end else begin
                    state_n = ST_WAIT_N;
                end
            end
            ST_SEND_HDR: begin
                txDriveRing   = 1'b1;
                txRingOut     = make_header(whichCore, type_r, len_r);
                txSlotTypeOut = msg_slot_s;
                txSrcDestOut  = dest_r;
                if (len_r == 6'd0) begin
                    sent     = gnt_oh_r;
                    rr_ptr_n = next_ptr_s;
                    state_n  = ST_IDLE;
                end else begin
                    cnt_n    = len_r;
                    state_n  = ST_SEND_PAY;
                end
            end
            ST_SEND_PAY: begin
                txDriveRing   = 1'b1;
                txRingOut     = reqData[gnt_r*32 +: 32];
                txSlotTypeOut = msg_slot_s;
                txSrcDestOut  = dest_r;
                dataRd        = gnt_oh_r;
                cnt_n         = cnt_r - 6'd1;
                if (cnt_r == 6'd1) begin
                    sent     = gnt_oh_r;
                    rr_ptr_n = next_ptr_s;
                    state_n  = ST_IDLE;
                end else begin
                    state_n  = ST_SEND_PAY;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ring_tx_arbiter.sv
// Directed self-checking bench for ring_tx_arbiter: passthrough, token capture,
// train skip, header/payload framing, broadcast rule, round-robin and reset.
module tb_ring_tx_arbiter;
    import ring_pkg::*;

    localparam int NREQ = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic [3:0]         whichCore, copyCore;
    logic [NREQ-1:0]    req;
    logic [4*NREQ-1:0]  reqDest, reqType;
    logic [6*NREQ-1:0]  reqLen;
    logic [32*NREQ-1:0] reqData;
    logic [NREQ-1:0]    dataRd, sent;
    logic [31:0]        RingIn, txRingOut;
    logic [3:0]         SlotTypeIn, SrcDestIn, txSlotTypeOut, txSrcDestOut;
    logic               txDriveRing, txWaiting;

    int num_checks = 0;
    int num_errors = 0;

    ring_tx_arbiter #(.NREQ(NREQ)) dut (
        .clock(clock), .reset(reset), .whichCore(whichCore), .copyCore(copyCore),
        .req(req), .reqDest(reqDest), .reqType(reqType), .reqLen(reqLen),
        .reqData(reqData), .dataRd(dataRd), .sent(sent),
        .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SrcDestIn(SrcDestIn),
        .txRingOut(txRingOut), .txSlotTypeOut(txSlotTypeOut),
        .txSrcDestOut(txSrcDestOut), .txDriveRing(txDriveRing), .txWaiting(txWaiting)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic set_null(input int n);
        RingIn     = 32'hCAFE_0000 | 32'(n);
        SlotTypeIn = SLOT_NULL;
        SrcDestIn  = 4'h6;
    endtask

    task automatic set_desc(input int i, input logic [3:0] d, input logic [3:0] t, input logic [5:0] l);
        reqDest[4*i +: 4] = d;
        reqType[4*i +: 4] = t;
        reqLen[6*i +: 6]  = l;
    endtask

    task automatic check_passthrough(input string tag);
        check_value({tag, "_drive"}, 32'(txDriveRing), 32'd0);
        check_value({tag, "_data"}, txRingOut, RingIn);
        check_value({tag, "_slot"}, 32'(txSlotTypeOut), 32'(SlotTypeIn));
        check_value({tag, "_sd"}, 32'(txSrcDestOut), 32'(SrcDestIn));
    endtask

    // Starts in an IDLE cycle with req[idx] already presented; ends in the next IDLE cycle
    task automatic run_msg(input int idx, input logic [31:0] tok, input logic [3:0] exp_slot);
        logic [3:0]      d, t;
        logic [5:0]      l;
        logic [NREQ-1:0] oh;
        logic [31:0]     word;
        int              skip;
        d  = reqDest[4*idx +: 4];
        t  = reqType[4*idx +: 4];
        l  = reqLen[6*idx +: 6];
        oh = '0;
        oh[idx] = 1'b1;
        set_null(0);
        sample();
        check_value("idle_wait", 32'(txWaiting), 32'd0);
        check_value("idle_sent", 32'(sent), 32'd0);
        check_value("idle_rd", 32'(dataRd), 32'd0);
        check_passthrough("idle");
        step();
        set_null(1);
        sample();
        check_value("wait_flag", 32'(txWaiting), 32'd1);
        check_passthrough("wait_null");
        step();
        RingIn = tok; SlotTypeIn = SLOT_TOKEN; SrcDestIn = 4'h0;
        sample();
        check_value("tok_drive", 32'(txDriveRing), 32'd1);
        check_value("tok_data", txRingOut, tok + 32'(l) + 32'd1);
        check_value("tok_slot", 32'(txSlotTypeOut), 32'(SLOT_TOKEN));
        step();
        skip = int'(tok[7:0]);
        for (int n = 0; n < skip; n++) begin
            RingIn = 32'h5A00_0000 | 32'(n); SlotTypeIn = SLOT_MESSAGE; SrcDestIn = 4'hE;
            sample();
            check_passthrough("skip");
            check_value("skip_wait", 32'(txWaiting), 32'd0);
            step();
        end
        set_null(2);
        sample();
        check_value("hdr_drive", 32'(txDriveRing), 32'd1);
        check_value("hdr_data", txRingOut, {18'd0, whichCore, t, l});
        check_value("hdr_slot", 32'(txSlotTypeOut), 32'(exp_slot));
        check_value("hdr_sd", 32'(txSrcDestOut), 32'(d));
        check_value("hdr_sent", 32'(sent), (l == 6'd0) ? 32'(oh) : 32'd0);
        check_value("hdr_rd", 32'(dataRd), 32'd0);
        step();
        for (int k = 0; k < int'(l); k++) begin
            word = {8'(idx), 8'hD0, 16'(k)};
            reqData[32*idx +: 32] = word;
            set_null(3 + k);
            sample();
            check_value("pay_drive", 32'(txDriveRing), 32'd1);
            check_value("pay_data", txRingOut, word);
            check_value("pay_slot", 32'(txSlotTypeOut), 32'(exp_slot));
            check_value("pay_sd", 32'(txSrcDestOut), 32'(d));
            check_value("pay_rd", 32'(dataRd), 32'(oh));
            check_value("pay_sent", 32'(sent), (k == int'(l) - 1) ? 32'(oh) : 32'd0);
            step();
        end
    endtask

    initial begin
        reset = 1'b0; whichCore = 4'd2; copyCore = 4'd5;
        req = '0; reqDest = '0; reqType = '0; reqLen = '0; reqData = '0;
        set_null(0);

        // Reset state with all requests up and a Token on the ring
        req = 4'b1111;
        step(); step();
        RingIn = 32'h0000_0004; SlotTypeIn = SLOT_TOKEN; SrcDestIn = 4'h1;
        sample();
        check_passthrough("rst");
        check_value("rst_wait", 32'(txWaiting), 32'd0);
        check_value("rst_rd", 32'(dataRd), 32'd0);
        check_value("rst_sent", 32'(sent), 32'd0);
        step();
        req = '0; reset = 1'b1;

        // Passthrough with no requests
        RingIn = 32'h0000_0003; SlotTypeIn = SLOT_TOKEN; SrcDestIn = 4'hB;
        sample(); check_passthrough("pt_tok"); step();
        RingIn = 32'h1357_9BDF; SlotTypeIn = SLOT_MESSAGE; SrcDestIn = 4'h3;
        sample(); check_passthrough("pt_msg"); check_value("pt_wait", 32'(txWaiting), 32'd0); step();

        // Single message, then a train skip that also wraps the pointer back to 0
        set_desc(0, 4'd3, 4'd5, 6'd2); req = 4'b0001;
        run_msg(0, 32'd0, SLOT_MESSAGE);
        set_desc(0, 4'd9, 4'd6, 6'd1);
        run_msg(0, 32'h1234_5605, SLOT_MESSAGE);
        req = '0;

        // Zero length: broadcast, non-broadcast boundary, and 4-bit wrap of whichCore+1
        set_desc(2, 4'd2, 4'd3, 6'd0); req = 4'b0100;
        run_msg(2, 32'h0000_0100, SLOT_BROADCAST);
        copyCore = 4'd3;
        run_msg(2, 32'h0000_0007, SLOT_MESSAGE);
        whichCore = 4'd15; copyCore = 4'd1; set_desc(2, 4'd15, 4'd3, 6'd0);
        run_msg(2, 32'd0, SLOT_BROADCAST);
        whichCore = 4'd2; copyCore = 4'd5; req = '0;

        // Round-robin from a fresh pointer with 4'b1011 held
        reset = 1'b0; step(); reset = 1'b1;
        set_desc(0, 4'd3, 4'd5, 6'd2);
        set_desc(1, 4'd7, 4'd9, 6'd1);
        set_desc(3, 4'd4, 4'd1, 6'd3);
        req = 4'b1011;
        run_msg(0, 32'd0, SLOT_MESSAGE);
        run_msg(1, 32'h0000_0002, SLOT_MESSAGE);
        run_msg(3, 32'd0, SLOT_MESSAGE);
        run_msg(0, 32'd0, SLOT_MESSAGE);

        // Reset during payload of requester 1 (pointer was 1), then pointer must be 0
        set_desc(1, 4'd5, 4'd2, 6'd3); req = 4'b0010;
        set_null(0); step();
        RingIn = 32'd0; SlotTypeIn = SLOT_TOKEN; step();
        set_null(1); sample(); check_value("mr_hdr", 32'(txDriveRing), 32'd1); step();
        reqData[32 +: 32] = 32'hBEEF_0001;
        sample();
        check_value("mr_rd", 32'(dataRd), 32'b0010);
        reset = 1'b0;
        check_value("mr_sent", 32'(sent), 32'd0);
        step();
        reset = 1'b1; req = 4'b0011;
        run_msg(0, 32'd0, SLOT_MESSAGE);
        req = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
